uart_rx_os: RTL and testbench

UART receiver with oversampled serial input. It is the receive-side counterpart of the team's UART transmitter and speaks the same frame format: 1 start bit (0), DATA_WIDTH data bits LSB first, an optional parity bit, and 1 stop bit (1). It runs on a single clock at Prescale × the bit rate. It majority-samples each bit, checks framing and parity, and delivers a parallel word with a one-cycle valid pulse.

---
 rtl/uart_rx_os.sv | 218 +++++++++++++++++++++
 tb/tb_uart_rx_os.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_os.sv
// rtl/uart_rx_os.sv - oversampled UART receiver with majority voting, parity and stop checking
//
// Receives frames of 1 start bit (0), DATA_WIDTH data bits LSB first, an
// optional parity bit and 1 stop bit (1). CLK runs at Prescale times the bit
// rate. Each bit is captured three times around its centre and resolved by
// majority vote.
//
// Ports:
//   CLK        oversampling clock
//   RST        synchronous reset, active high
//   RX_IN      serial line, idles high, already synchronised to CLK
//   PAR_EN     1 = frame carries a parity bit (latched at start detection)
//   PAR_TYP    0 = even parity, 1 = odd parity (latched at start detection)
//   Prescale   oversampling ratio, 8/16/32 (latched at start detection)
//   P_DATA     last good received word
//   Data_Valid one-cycle pulse when P_DATA holds a new error-free word
//   Par_Err    one-cycle pulse on parity mismatch
//   Stp_Err    one-cycle pulse when the stop bit is sampled as 0

module uart_rx_os #(
    parameter int DATA_WIDTH = 8,
    parameter int PRESCALE_W = 6
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  RX_IN,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    input  logic [PRESCALE_W-1:0] Prescale,
    output logic [DATA_WIDTH-1:0] P_DATA,
    output logic                  Data_Valid,
    output logic                  Par_Err,
    output logic                  Stp_Err
);

    localparam int BIT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    state_t                state_q, state_d;

    logic [PRESCALE_W-1:0] edge_q, edge_d;
    logic [BIT_W-1:0]      bit_q, bit_d;
    logic [PRESCALE_W-1:0] presc_q, presc_d;
    logic                  par_en_q, par_en_d;
    logic                  par_typ_q, par_typ_d;
    logic [2:0]            smp_q, smp_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic                  frame_err_q, frame_err_d;
    logic [DATA_WIDTH-1:0] p_data_q, p_data_d;
    logic                  dv_q, dv_d;
    logic                  pe_q, pe_d;
    logic                  se_q, se_d;

    logic [PRESCALE_W-1:0] half;
    logic                  bit_end;
    logic                  last_bit;
    logic                  maj;
    logic                  parity_exp;
    logic                  start_det;
    logic                  restart;

    assign half       = presc_q >> 1;
    assign bit_end    = (edge_q == (presc_q - PRESCALE_W'(1)));
    assign last_bit   = (bit_q == BIT_W'(DATA_WIDTH - 1));
    assign maj        = (smp_q[0] & smp_q[1]) | (smp_q[0] & smp_q[2]) | (smp_q[1] & smp_q[2]);
    assign parity_exp = (^shift_q) ^ par_typ_q;
    assign start_det  = (state_q == IDLE) && !RX_IN;
    // A low line at the end of the stop bit is the start bit of the next frame.
    assign restart    = (state_q == STOP) && bit_end && !RX_IN;

    // State register and all datapath registers
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= IDLE;
            edge_q      <= '0;
            bit_q       <= '0;
            presc_q     <= '0;
            par_en_q    <= 1'b0;
            par_typ_q   <= 1'b0;
            smp_q       <= '0;
            shift_q     <= '0;
            frame_err_q <= 1'b0;
            p_data_q    <= '0;
            dv_q        <= 1'b0;
            pe_q        <= 1'b0;
            se_q        <= 1'b0;
        end else begin
            state_q     <= state_d;
            edge_q      <= edge_d;
            bit_q       <= bit_d;
            presc_q     <= presc_d;
            par_en_q    <= par_en_d;
            par_typ_q   <= par_typ_d;
            smp_q       <= smp_d;
            shift_q     <= shift_d;
            frame_err_q <= frame_err_d;
            p_data_q    <= p_data_d;
            dv_q        <= dv_d;
            pe_q        <= pe_d;
            se_q        <= se_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (!RX_IN) begin
                    state_d = START;
                end
            end
            START: begin
                // A start bit that votes high was a glitch.
                if (bit_end) begin
                    state_d = maj ? IDLE : DATA;
                end
            end
            DATA: begin
                if (bit_end && last_bit) begin
                    state_d = par_en_q ? PARITY : STOP;
                end
            end
            PARITY: begin
                if (bit_end) begin
                    state_d = STOP;
                end
            end
            STOP: begin
                if (bit_end) begin
                    state_d = RX_IN ? IDLE : START;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Datapath and registered output next values
    always_comb begin
        edge_d      = edge_q;
        bit_d       = bit_q;
        presc_d     = presc_q;
        par_en_d    = par_en_q;
        par_typ_d   = par_typ_q;
        smp_d       = smp_q;
        shift_d     = shift_q;
        frame_err_d = frame_err_q;
        p_data_d    = p_data_q;
        dv_d        = 1'b0;
        pe_d        = 1'b0;
        se_d        = 1'b0;

        // Bit timing: edge counter idles at 0 and wraps at every bit end.
        if (state_q == IDLE || bit_end) begin
            edge_d = '0;
        end else begin
            edge_d = edge_q + PRESCALE_W'(1);
        end

        // Three captures centred on the middle of the bit.
        if (state_q != IDLE) begin
            if (edge_q == half - PRESCALE_W'(1)) begin
                smp_d[0] = RX_IN;
            end
            if (edge_q == half) begin
                smp_d[1] = RX_IN;
            end
            if (edge_q == half + PRESCALE_W'(1)) begin
                smp_d[2] = RX_IN;
            end
        end

        // Frame configuration is frozen for the whole frame.
        if (start_det || restart) begin
            presc_d     = Prescale;
            par_en_d    = PAR_EN;
            par_typ_d   = PAR_TYP;
            bit_d       = '0;
            frame_err_d = 1'b0;
        end

        if (bit_end) begin
            case (state_q)
                DATA: begin
                    shift_d = {maj, shift_q[DATA_WIDTH-1:1]};
                    bit_d   = last_bit ? '0 : bit_q + BIT_W'(1);
                end
                PARITY: begin
                    if (maj != parity_exp) begin
                        pe_d        = 1'b1;
                        frame_err_d = 1'b1;
                    end
                end
                STOP: begin
                    se_d = ~maj;
                    if (maj && !frame_err_q) begin
                        dv_d     = 1'b1;
                        p_data_d = shift_q;
                    end
                end
                default: ;
            endcase
        end
    end

    assign P_DATA     = p_data_q;
    assign Data_Valid = dv_q;
    assign Par_Err    = pe_q;
    assign Stp_Err    = se_q;

endmodule

// File: tb/tb_uart_rx_os.sv
// tb/tb_uart_rx_os.sv - scoreboard testbench for uart_rx_os

module tb_uart_rx_os;

    logic       CLK;
    logic       RST;
    logic       RX_IN;
    logic       PAR_EN;
    logic       PAR_TYP;
    logic [5:0] Prescale;
    logic [7:0] P_DATA;
    logic       Data_Valid;
    logic       Par_Err;
    logic       Stp_Err;

    uart_rx_os #(
        .DATA_WIDTH(8),
        .PRESCALE_W(6)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .RX_IN      (RX_IN),
        .PAR_EN     (PAR_EN),
        .PAR_TYP    (PAR_TYP),
        .Prescale   (Prescale),
        .P_DATA     (P_DATA),
        .Data_Valid (Data_Valid),
        .Par_Err    (Par_Err),
        .Stp_Err    (Stp_Err)
    );

    // kind: 0 = Data_Valid, 1 = Par_Err, 2 = Stp_Err
    typedef struct {
        int kind;
        int data;
        int cyc;
    } ev_t;

    ev_t exp_q[$];
    int  snap_q[$];
    int  cyc = 0;
    int  checks = 0;
    int  errors = 0;
    bit  done = 1'b0;
    int  last_good = 0;

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    always @(posedge CLK) cyc <= cyc + 1;

    // ---------------- monitor / scoreboard ----------------
    task automatic chk(input string name, input int got, input int expv);
        checks = checks + 1;
        if (got != expv) begin
            errors = errors + 1;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, expv, cyc);
        end
    endtask

    task automatic take(input int kind);
        ev_t e;
        if (exp_q.size() == 0) begin
            checks = checks + 1;
            errors = errors + 1;
            $display("FAIL unexpected_pulse: kind %0d at cycle %0d, none expected", kind, cyc);
        end else begin
            e = exp_q.pop_front();
            chk("event_kind", kind, e.kind);
            chk("event_cycle", cyc, e.cyc);
            chk("p_data", int'(P_DATA), e.data);
        end
    endtask

    always @(negedge CLK) begin
        if (snap_q.size() > 0 && snap_q[0] == cyc) begin
            void'(snap_q.pop_front());
            chk("reset_p_data", int'(P_DATA), 0);
            chk("reset_data_valid", int'(Data_Valid), 0);
            chk("reset_par_err", int'(Par_Err), 0);
            chk("reset_stp_err", int'(Stp_Err), 0);
        end
        if (!RST) begin
            if (Data_Valid) take(0);
            if (Par_Err)    take(1);
            if (Stp_Err)    take(2);
        end
        if (done) begin
            while (exp_q.size() > 0) begin
                ev_t e;
                e = exp_q.pop_front();
                checks = checks + 1;
                errors = errors + 1;
                $display("FAIL missing_event: kind %0d expected at cycle %0d never seen", e.kind, e.cyc);
            end
            $display("Result: errors=%0d of %0d checks", errors, checks);
            $finish;
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic send_frame(input int p, input bit pe, input bit pt, input logic [7:0] d,
                              input bit pbit, input bit sbit, input bit noise, input bit bump,
                              input bit exp_dv, input bit exp_pe, input bit exp_se);
        int  nb;
        int  n0;
        bit  v;
        nb       = pe ? 11 : 10;
        Prescale = 6'(p);
        PAR_EN   = pe;
        PAR_TYP  = pt;
        n0       = cyc;
        if (exp_pe) exp_q.push_back('{kind: 1, data: last_good, cyc: n0 + 1 + p * 10});
        if (exp_se) exp_q.push_back('{kind: 2, data: last_good, cyc: n0 + 1 + p * nb});
        if (exp_dv) begin
            exp_q.push_back('{kind: 0, data: int'(d), cyc: n0 + 1 + p * nb});
            last_good = int'(d);
        end
        for (int k = 0; k < nb; k++) begin
            if (k == 0)                v = 1'b0;
            else if (k <= 8)           v = d[k-1];
            else if (pe && k == 9)     v = pbit;
            else                       v = sbit;
            for (int j = 0; j < p; j++) begin
                RX_IN = (noise && j == p / 2 + 1) ? ~v : v;
                if (bump && k == 1 && j == 0) Prescale = 6'd16;
                tick(1);
            end
        end
        RX_IN    = 1'b1;
        Prescale = 6'(p);
    endtask

    initial begin
        logic [7:0] partial;
        RST      = 1'b1;
        RX_IN    = 1'b1;
        PAR_EN   = 1'b0;
        PAR_TYP  = 1'b0;
        Prescale = 6'd8;
        tick(2);
        snap_q.push_back(cyc);
        tick(1);
        RST = 1'b0;
        tick(3);

        //           p   pe  pt  data   pbit sbit noise bump  dv pe se
        send_frame(  8, 0, 0, 8'hA5, 0, 1, 0, 0,   1, 0, 0); tick(5);
        send_frame( 16, 1, 0, 8'h3C, 0, 1, 0, 0,   1, 0, 0); tick(5);
        send_frame( 16, 1, 0, 8'h3C, 1, 1, 0, 0,   0, 1, 0); tick(5);
        send_frame( 32, 1, 1, 8'h81, 1, 0, 0, 0,   0, 0, 1); tick(5);
        send_frame( 32, 1, 1, 8'h55, 1, 1, 0, 0,   1, 0, 0); tick(5);

        // start glitch, two cycles low
        Prescale = 6'd8;
        PAR_EN   = 1'b0;
        RX_IN    = 1'b0;
        tick(2);
        RX_IN = 1'b1;
        tick(20);

        send_frame(  8, 0, 0, 8'h0F, 0, 1, 0, 0,   1, 0, 0); tick(5);
        send_frame( 16, 0, 0, 8'hC3, 0, 1, 1, 0,   1, 0, 0); tick(5);

        // back-to-back
        send_frame(  8, 0, 0, 8'h12, 0, 1, 0, 0,   1, 0, 0);
        send_frame(  8, 0, 0, 8'h34, 0, 1, 0, 0,   1, 0, 0);

        // third frame aborted by reset after start + 4 data bits
        partial = 8'h99;
        RX_IN   = 1'b0;
        tick(8);
        for (int k = 0; k < 4; k++) begin
            RX_IN = partial[k];
            tick(8);
        end
        RST   = 1'b1;
        RX_IN = 1'b1;
        tick(1);
        snap_q.push_back(cyc);
        last_good = 0;
        tick(1);
        RST = 1'b0;
        tick(1);
        snap_q.push_back(cyc);
        tick(10);

        // Prescale disturbed mid-frame must be ignored
        send_frame(  8, 0, 0, 8'h5A, 0, 1, 0, 1,   1, 0, 0); tick(5);
        // parity and stop errors in the same frame
        send_frame(  8, 1, 0, 8'hFF, 1, 0, 0, 0,   0, 1, 1); tick(5);
        send_frame(  8, 1, 1, 8'h01, 0, 1, 0, 0,   1, 0, 0);

        for (int i = 0; i < 500; i++) begin
            if (exp_q.size() == 0) break;
            tick(1);
        end
        tick(20);
        done = 1'b1;
    end

endmodule
